keypad_scanner: RTL



---
 rtl/keypad_scanner.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column drive, synchronizes the
// active-low rows, debounces one key at a time and reports its hex code.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_rows,
    output logic [3:0] o_cols,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_key_pressed
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   div;
    logic [1:0]         col, col_n;
    logic [1:0]         row, row_n;
    logic [CNT_W-1:0]   deb_cnt, deb_n;
    logic [CNT_W-1:0]   rel_cnt, rel_n;
    logic [3:0]         rows_meta, rows_sync;
    logic [3:0]         code, code_n;
    logic               valid, valid_n;
    logic               pressed, pressed_n;

    logic               tick;
    logic               any_low;
    logic [1:0]         win_row;
    logic               row_low;
    logic [CNT_W-1:0]   deb_inc, rel_inc;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'hE;
            4'b11_01: k = 4'h0;
            4'b11_10: k = 4'hF;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    // Rows are asynchronous to clk; only the second flop is ever looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
        end else begin
            rows_meta <= i_rows;
            rows_sync <= rows_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= '0;
        else if (tick)
            div <= '0;
        else
            div <= div + DIV_W'(1);
    end

    assign tick    = (div == DIV_W'(SCAN_DIV - 1));
    assign any_low = ~&rows_sync;
    assign row_low = ~rows_sync[row];
    assign deb_inc = deb_cnt + CNT_W'(1);
    assign rel_inc = rel_cnt + CNT_W'(1);

    always_comb begin
        win_row = 2'd3;
        if (!rows_sync[2]) win_row = 2'd2;
        if (!rows_sync[1]) win_row = 2'd1;
        if (!rows_sync[0]) win_row = 2'd0;
    end

    always_comb begin
        state_n   = state;
        col_n     = col;
        row_n     = row;
        deb_n     = deb_cnt;
        rel_n     = rel_cnt;
        code_n    = code;
        valid_n   = 1'b0;
        pressed_n = pressed;
        case (state)
            SCAN: begin
                if (tick) begin
                    if (any_low) begin
                        row_n   = win_row;
                        deb_n   = CNT_W'(1);
                        state_n = DEBOUNCE;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (row_low) begin
                        deb_n = deb_inc;
                        if (deb_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            code_n    = key_map(row, col);
                            valid_n   = 1'b1;
                            pressed_n = 1'b1;
                            rel_n     = '0;
                            state_n   = HELD;
                        end
                    end else begin
                        state_n = SCAN;
                        col_n   = col + 2'd1;
                    end
                end
            end
            HELD: begin
                // Only the latched row matters; other rows in this column are ignored.
                if (tick) begin
                    if (row_low) begin
                        rel_n = '0;
                    end else if (rel_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                        rel_n     = '0;
                        pressed_n = 1'b0;
                        state_n   = SCAN;
                        col_n     = col + 2'd1;
                    end else begin
                        rel_n = rel_inc;
                    end
                end
            end
            default: begin
                state_n = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SCAN;
            col     <= 2'd0;
            row     <= 2'd0;
            deb_cnt <= '0;
            rel_cnt <= '0;
            code    <= 4'h0;
            valid   <= 1'b0;
            pressed <= 1'b0;
        end else begin
            state   <= state_n;
            col     <= col_n;
            row     <= row_n;
            deb_cnt <= deb_n;
            rel_cnt <= rel_n;
            code    <= code_n;
            valid   <= valid_n;
            pressed <= pressed_n;
        end
    end

    assign o_cols        = ~(4'b0001 << col);
    assign o_key_code    = code;
    assign o_key_valid   = valid;
    assign o_key_pressed = pressed;

endmodule
